// File: rtl/dmem_port_arbiter_if.sv
// Bundle of both requester ports, the ip_ram port and the statistics outputs
// seen by dmem_port_arbiter (slave) and by whoever drives it (master).
interface dmem_port_arbiter_if #(
    parameter int AW = 14
);
    logic           rden_a;
    logic           wren_a;
    logic           lock_a;
    logic [AW-1:0]  addr_a;
    logic [31:0]    byteena_a;
    logic [255:0]   wdata_a;
    logic           stall_a;
    logic           rvalid_a;
    logic [255:0]   rdata_a;

    logic           req_b;
    logic           we_b;
    logic           lock_b;
    logic [AW-1:0]  addr_b;
    logic [31:0]    byteena_b;
    logic [255:0]   wdata_b;
    logic           gnt_b;
    logic           rvalid_b;
    logic [255:0]   rdata_b;

    logic           rden;
    logic           wren;
    logic [AW-1:0]  ip_address;
    logic [31:0]    byteena;
    logic [255:0]   writeData;
    logic [255:0]   readData;

    logic [31:0]    stat_conflicts;
    logic [15:0]    stat_b_forced;

    modport slave (
        input  rden_a, wren_a, lock_a, addr_a, byteena_a, wdata_a,
        input  req_b, we_b, lock_b, addr_b, byteena_b, wdata_b,
        input  readData,
        output stall_a, rvalid_a, rdata_a,
        output gnt_b, rvalid_b, rdata_b,
        output rden, wren, ip_address, byteena, writeData,
        output stat_conflicts, stat_b_forced
    );

    modport master (
        output rden_a, wren_a, lock_a, addr_a, byteena_a, wdata_a,
        output req_b, we_b, lock_b, addr_b, byteena_b, wdata_b,
        output readData,
        input  stall_a, rvalid_a, rdata_a,
        input  gnt_b, rvalid_b, rdata_b,
        input  rden, wren, ip_address, byteena, writeData,
        input  stat_conflicts, stat_b_forced
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the ip_ram data port: A-priority with B anti-starvation,
// lock ownership and read-return tagging. Define DMEM_ARB_STATS_EN for stat counters.
module dmem_port_arbiter #(
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 8,
    parameter int AW       = 14
) (
    input logic              clk,
    input logic              reset,
    dmem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_t;

    localparam logic [7:0] WMAX = 8'(MAX_WAIT);

    state_t        state, state_nx;
    logic [7:0]    wait_b, wait_nx;
    logic          req_a;
    logic          grant_a, grant_b;
    logic          use_a, use_b;
    logic          force_b;
    logic          rd_go, wr_go;
    logic [AW-1:0] addr_mux;
    logic [31:0]   be_mux;
    logic [255:0]  wd_mux;
    logic [RD_LAT-1:0] tag_v, tag_b;

    assign req_a = bus.rden_a | bus.wren_a;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            wait_b <= '0;
        end else begin
            state  <= state_nx;
            wait_b <= wait_nx;
        end
    end

    always_comb begin
        grant_a  = 1'b0;
        grant_b  = 1'b0;
        force_b  = 1'b0;
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (req_a && bus.req_b) begin
                    force_b = (wait_b == WMAX);
                    grant_b = force_b;
                    grant_a = !force_b;
                end else begin
                    grant_a = req_a;
                    grant_b = bus.req_b;
                end
                if (grant_a && bus.lock_a)
                    state_nx = LOCK_A;
                else if (grant_b && bus.lock_b)
                    state_nx = LOCK_B;
            end
            LOCK_A: begin
                grant_a = 1'b1;
                if (!bus.lock_a)
                    state_nx = IDLE;
            end
            LOCK_B: begin
                grant_b = 1'b1;
                if (!bus.lock_b)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign use_a = grant_a & req_a;
    assign use_b = grant_b & bus.req_b;

    always_comb begin
        rd_go    = 1'b0;
        wr_go    = 1'b0;
        addr_mux = '0;
        be_mux   = '0;
        wd_mux   = '0;
        if (use_a) begin
            wr_go    = bus.wren_a;
            rd_go    = bus.rden_a & ~bus.wren_a;
            addr_mux = bus.addr_a;
            be_mux   = bus.byteena_a;
            wd_mux   = bus.wdata_a;
        end else if (use_b) begin
            wr_go    = bus.we_b;
            rd_go    = ~bus.we_b;
            addr_mux = bus.addr_b;
            be_mux   = bus.byteena_b;
            wd_mux   = bus.wdata_b;
        end
    end

    // A lock freezes the starvation count so the override never breaks it.
    always_comb begin
        wait_nx = wait_b;
        if (!bus.req_b || use_b)
            wait_nx = '0;
        else if (state != LOCK_A && wait_b != WMAX)
            wait_nx = wait_b + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_v <= '0;
            tag_b <= '0;
        end else begin
            tag_v[0] <= rd_go;
            tag_b[0] <= use_b;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_b[i] <= tag_b[i-1];
            end
        end
    end

    assign bus.stall_a    = req_a & ~grant_a;
    assign bus.gnt_b      = use_b;
    assign bus.rden       = rd_go;
    assign bus.wren       = wr_go;
    assign bus.ip_address = addr_mux;
    assign bus.byteena    = be_mux;
    assign bus.writeData  = wd_mux;
    assign bus.rvalid_a   = tag_v[RD_LAT-1] & ~tag_b[RD_LAT-1];
    assign bus.rvalid_b   = tag_v[RD_LAT-1] & tag_b[RD_LAT-1];
    assign bus.rdata_a    = bus.rvalid_a ? bus.readData : '0;
    assign bus.rdata_b    = bus.rvalid_b ? bus.readData : '0;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] conf_q;
    logic [15:0] forced_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            conf_q   <= '0;
            forced_q <= '0;
        end else begin
            if (req_a && bus.req_b)
                conf_q <= conf_q + 32'd1;
            if (force_b && forced_q != 16'hFFFF)
                forced_q <= forced_q + 16'd1;
        end
    end

    assign bus.stat_conflicts = conf_q;
    assign bus.stat_b_forced  = forced_q;
`else
    assign bus.stat_conflicts = '0;
    assign bus.stat_b_forced  = '0;
`endif
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized bench for dmem_port_arbiter against a cycle-level behavioural model.
// Stat counter expectations follow DMEM_ARB_STATS_EN.
module tb_dmem_port_arbiter;
    localparam int RD_LAT   = 3;
    localparam int MAX_WAIT = 8;
    localparam int AW       = 14;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.AW(AW)) bus ();

    dmem_port_arbiter #(
        .RD_LAT(RD_LAT),
        .MAX_WAIT(MAX_WAIT),
        .AW(AW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: who holds the port (0 none, 1 A, 2 B), refusal count,
    // read returns keyed by the cycle they are due, and stat totals.
    int          own;
    int          wcnt;
    int          cyc;
    int          due[int];
    logic [31:0] m_conf;
    int          m_forced;
    logic        last_gnt_b;

    task automatic check(string tag, logic [255:0] got, logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic idle_in();
        bus.rden_a    = 1'b0;
        bus.wren_a    = 1'b0;
        bus.lock_a    = 1'b0;
        bus.addr_a    = '0;
        bus.byteena_a = '0;
        bus.wdata_a   = '0;
        bus.req_b     = 1'b0;
        bus.we_b      = 1'b0;
        bus.lock_b    = 1'b0;
        bus.addr_b    = '0;
        bus.byteena_b = '0;
        bus.wdata_b   = '0;
        reset         = 1'b0;
    endtask

    // One clock cycle: inputs are already applied; predict, compare, advance.
    task automatic step();
        logic          ra;
        logic          ovr;
        int            win;
        logic          e_rd, e_wr;
        logic [AW-1:0] e_ad;
        logic [31:0]   e_be;
        logic [255:0]  e_wd;
        logic [255:0]  rd;
        int            ret;

        rd = {8{$urandom}};
        bus.readData = rd;
        ra  = bus.rden_a | bus.wren_a;
        ovr = 1'b0;
        if (own != 0)
            win = own;
        else if (ra && bus.req_b) begin
            ovr = (wcnt == MAX_WAIT);
            win = ovr ? 2 : 1;
        end else if (ra)
            win = 1;
        else if (bus.req_b)
            win = 2;
        else
            win = 0;

        e_rd = 1'b0; e_wr = 1'b0; e_ad = '0; e_be = '0; e_wd = '0;
        if (win == 1 && ra) begin
            e_wr = bus.wren_a;
            e_rd = !bus.wren_a;
            e_ad = bus.addr_a;
            e_be = bus.byteena_a;
            e_wd = bus.wdata_a;
        end else if (win == 2 && bus.req_b) begin
            e_wr = bus.we_b;
            e_rd = !bus.we_b;
            e_ad = bus.addr_b;
            e_be = bus.byteena_b;
            e_wd = bus.wdata_b;
        end
        ret = due.exists(cyc) ? due[cyc] : 0;

        @(negedge clk);
        last_gnt_b = bus.gnt_b;
        check("stall_a", bus.stall_a, ra && win != 1);
        check("gnt_b", bus.gnt_b, bus.req_b && win == 2);
        check("rden", bus.rden, e_rd);
        check("wren", bus.wren, e_wr);
        check("ip_address", bus.ip_address, e_ad);
        check("byteena", bus.byteena, e_be);
        check("writeData", bus.writeData, e_wd);
        check("rvalid_a", bus.rvalid_a, ret == 1);
        check("rvalid_b", bus.rvalid_b, ret == 2);
        check("rdata_a", bus.rdata_a, (ret == 1) ? rd : 256'd0);
        check("rdata_b", bus.rdata_b, (ret == 2) ? rd : 256'd0);
`ifdef DMEM_ARB_STATS_EN
        check("stat_conflicts", bus.stat_conflicts, m_conf);
        check("stat_b_forced", bus.stat_b_forced, m_forced);
`else
        check("stat_conflicts", bus.stat_conflicts, 0);
        check("stat_b_forced", bus.stat_b_forced, 0);
`endif

        if (reset) begin
            own = 0;
            wcnt = 0;
            due.delete();
            m_conf = '0;
            m_forced = 0;
        end else begin
            if (e_rd)
                due[cyc + RD_LAT] = win;
            if (ra && bus.req_b)
                m_conf = m_conf + 1;
            if (ovr && m_forced < 65535)
                m_forced++;
            if (!bus.req_b || (win == 2))
                wcnt = 0;
            else if (own != 1 && wcnt < MAX_WAIT)
                wcnt++;
            if (own == 1)
                own = bus.lock_a ? 1 : 0;
            else if (own == 2)
                own = bus.lock_b ? 2 : 0;
            else if (win == 1 && bus.lock_a)
                own = 1;
            else if (win == 2 && bus.lock_b)
                own = 2;
        end
        due.delete(cyc);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_in();
        idle_in();
        if ($urandom_range(9) < 5) begin
            bus.rden_a = 1'($urandom);
            bus.wren_a = 1'($urandom);
            if (!bus.rden_a && !bus.wren_a)
                bus.rden_a = 1'b1;
        end
        bus.lock_a    = ($urandom_range(2) == 0);
        bus.addr_a    = AW'($urandom);
        bus.byteena_a = $urandom;
        bus.wdata_a   = {8{$urandom}};
        bus.req_b     = ($urandom_range(9) < 5);
        bus.we_b      = 1'($urandom);
        bus.lock_b    = ($urandom_range(2) == 0);
        bus.addr_b    = AW'($urandom);
        bus.byteena_b = $urandom;
        bus.wdata_b   = {8{$urandom}};
        reset         = ($urandom_range(149) == 0);
    endtask

    initial begin
        int refused;
        bit got;

        idle_in();
        bus.readData = '0;
        reset = 1'b1;
        own = 0; wcnt = 0; cyc = 0; m_conf = '0; m_forced = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        repeat (2) step();

        // single A read
        bus.rden_a = 1'b1;
        bus.addr_a = 14'h0010;
        bus.byteena_a = '1;
        step();
        idle_in();
        repeat (RD_LAT + 1) step();

        // B starved by continuous A writes until the override
        bus.wren_a = 1'b1;
        bus.addr_a = 14'h0030;
        bus.wdata_a = {8{32'hA5A5_0001}};
        bus.req_b = 1'b1;
        bus.we_b = 1'b1;
        bus.addr_b = 14'h0100;
        bus.wdata_b = {8{32'h0B0B_0002}};
        refused = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (last_gnt_b)
                got = 1'b1;
            else
                refused++;
        end
        check("starve_refusals", refused, MAX_WAIT);
        idle_in();
        repeat (2) step();

        // A locked vector read, B waiting throughout
        bus.rden_a = 1'b1;
        bus.lock_a = 1'b1;
        bus.addr_a = 14'h0020;
        bus.req_b = 1'b1;
        bus.addr_b = 14'h0040;
        step();
        bus.addr_a = 14'h0021;
        step();
        bus.lock_a = 1'b0;
        bus.addr_a = 14'h0022;
        step();
        bus.rden_a = 1'b0;
        step();
        idle_in();
        repeat (RD_LAT + 1) step();

        // B burst of 4 writes, A arrives on the second beat
        bus.req_b = 1'b1;
        bus.we_b = 1'b1;
        bus.lock_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.addr_b = AW'(14'h0200 + i);
            bus.wdata_b = {8{32'(i)}};
            bus.lock_b = (i < 3);
            if (i == 1) begin
                bus.wren_a = 1'b1;
                bus.addr_a = 14'h0050;
            end
            step();
        end
        bus.req_b = 1'b0;
        bus.lock_b = 1'b0;
        step();
        idle_in();
        step();

        // alternating owners on back-to-back reads
        bus.rden_a = 1'b1; bus.addr_a = 14'h0060;
        step();
        idle_in();
        bus.req_b = 1'b1; bus.addr_b = 14'h0061;
        step();
        idle_in();
        bus.rden_a = 1'b1; bus.addr_a = 14'h0062;
        step();
        idle_in();
        repeat (RD_LAT + 2) step();

        // reset right behind a granted read
        bus.rden_a = 1'b1; bus.addr_a = 14'h0070;
        step();
        idle_in();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (RD_LAT + 1) step();

        // five conflict cycles
        bus.rden_a = 1'b1;
        bus.req_b = 1'b1;
        repeat (5) step();
        idle_in();
        repeat (2) step();

        for (int i = 0; i < 3000; i++) begin
            rand_in();
            step();
        end
        idle_in();
        repeat (RD_LAT + 2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Arbitrates the single data-memory ip_ram port between two requesters. Requester A is the core's data aligner path; requester B is the host/key-loader path that preloads AES keys and plaintext blocks and reads back ciphertext. The block sits between both requesters and the ip_ram. It handles fixed priority with anti-starvation, locked multi-cycle ownership for unaligned vector accesses and bursts, and read-return routing across the RAM read latency.

Parameters:
RD_LAT, 1, ip_ram read latency in cycles (1..4)
MAX_WAIT, 8, cycles B may be refused before it gains priority over A (1..255)
AW, 14, ip_ram word address width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
rden_a  in  1  A read request
wren_a  in  1  A write request
lock_a  in  1  A needs the port next cycle too (data aligner busy)
addr_a  in  AW  A 256-bit-aligned address
byteena_a  in  32  A byte enables
wdata_a  in  256  A write data
stall_a  out  1  A request not granted this cycle (to hazard unit)
rvalid_a  out  1  read data for A valid
rdata_a  out  256  read data for A
req_b  in  1  B request
we_b  in  1  B write (1) / read (0)
lock_b  in  1  B burst: keep the port next cycle
addr_b  in  AW  B address
byteena_b  in  32  B byte enables
wdata_b  in  256  B write data
gnt_b  out  1  B request accepted this cycle
rvalid_b  out  1  read data for B valid
rdata_b  out  256  read data for B
rden  out  1  ip_ram read enable
wren  out  1  ip_ram write enable
ip_address  out  AW  ip_ram address
byteena  out  32  ip_ram byte enables
writeData  out  256  ip_ram write data
readData  in  256  ip_ram read data
stat_conflicts  out  32  cycles with A and B both requesting (optional feature)
stat_b_forced  out  16  grants to B by starvation override (optional feature)

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Request definitions: req_a = rden_a | wren_a. If rden_a and wren_a are both high, the write takes precedence and no read is issued.
- FSM states: IDLE, LOCK_A, LOCK_B.
- IDLE:
  - Only A requesting: grant A.
  - Only B requesting: grant B.
  - Both requesting: grant A unless wait_b == MAX_WAIT, in which case grant B.
  - Next state: if the granted side's lock is high, go to LOCK_x; otherwise stay in IDLE.
- LOCK_A: A granted every cycle; B refused. Return to IDLE at the edge where lock_a = 0. A is still granted in that final cycle.
- LOCK_B: symmetric to LOCK_A. B is granted only on cycles where req_b = 1; the port is idle otherwise, but ownership is held.
- Grant outputs (combinational, same cycle):
  - stall_a = req_a & ~grant_a.
  - gnt_b = req_b & grant_b.
- RAM mux:
  - Granted side's address, byteena and writeData drive the ip_ram outputs.
  - rden and wren follow the granted request type.
  - No grant: rden = wren = 0; ip_address, byteena and writeData are all 0.
- wait_b counter:
  - Increments each cycle req_b & ~gnt_b, saturating at MAX_WAIT.
  - Clears on gnt_b or when req_b = 0.
  - Not incremented while in LOCK_A; the override applies only in IDLE and never breaks a lock.
- Read return:
  - RD_LAT-deep shift register of {valid, owner}, pushed on every granted read.
  - rvalid_x asserts exactly RD_LAT cycles after the granted read cycle.
  - rdata_x = readData when the tag matches x, else 0.
  - Back-to-back reads from alternating owners must return in order with correct tags.
- Reset values: state IDLE, wait_b 0, tag pipe cleared, stat counters 0.
  - With no requests: stall_a = 0, gnt_b = 0, rvalid_a/b = 0, all RAM outputs 0.
  - Reset during a lock or with reads in flight: lock dropped, and rvalid for in-flight reads is never asserted.
- Simultaneous lock_a and lock_b in IDLE: only the winner's lock is honoured.

Optional Feature:
Macro DMEM_ARB_STATS_EN.
- Defined: stat_conflicts increments each cycle req_a & req_b (wrapping). stat_b_forced increments on each starvation-override grant to B (saturating at 16'hFFFF). Both clear on reset.
- Undefined: both stat ports are driven constant 0 and no counter flops are instantiated.

Test Plan:
- Reset, then A read addr 14'h0010 alone → rden = 1, ip_address = 14'h0010, stall_a = 0. With RD_LAT = 1, rvalid_a = 1 next cycle, rdata_a = readData, rvalid_b = 0.
- A writes continuously with lock_a = 0 and B writes addr 14'h0100 continuously → B refused 8 cycles (stall none on A). On cycle 9, gnt_b = 1, stall_a = 1, wren = 1, ip_address = 14'h0100, wait_b back to 0.
- A unaligned vector read, lock_a high 2 cycles with addr 14'h0020 then 14'h0021; B requesting throughout → stall_a = 0 for all 3 cycles, gnt_b = 0 until the cycle after lock_a falls.
- B burst of 4 writes (addr 14'h0200–14'h0203, lock_b high for the first 3) while A requests at the second burst cycle → stall_a = 1 for 3 cycles, then A is granted.
- Alternating reads A/B/A with RD_LAT = 3 → rvalid_a, rvalid_b, rvalid_a on cycles 3, 4, 5 with correct tags.
- Reset asserted one cycle after a granted read with RD_LAT = 2 → no rvalid pulse. With DMEM_ARB_STATS_EN, stat_conflicts reads 0 after reset and 5 after 5 conflict cycles.
